pipe_run_ctrl: RTL and testbench
================================

Name: pipe_run_ctrl

Overview:
- Run/step/halt controller for the 5-stage MIPS pipeline.
- Generates the single pipeline clock enable `cpu_en` that every pipeline register, the PC and the statistics counters qualify on.
- Sequences free-run, single-step, PC breakpoint and program termination (syscall exit in WB).
- Debounces the board run/step/halt buttons.

Parameters:
- DEBOUNCE, 20000, number of consecutive stable clk cycles a button must hold before it is accepted.
- CNT_W, 32, width of the enabled-cycle counter.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous active-high reset.
- btn_run  in  1  raw run button, asynchronous level.
- btn_step  in  1  raw single-step button, asynchronous level.
- btn_halt  in  1  raw pause button, asynchronous level.
- halt_req  in  1  WB stage holds the exit syscall (level, reflects the current WB register).
- wb_pc  in  32  PC+4 of the instruction currently in WB.
- bp_en  in  1  breakpoint enable (switch, static).
- bp_addr  in  32  breakpoint address, compared against wb_pc.
- cpu_en  out  1  pipeline advance enable.
- run_state  out  2  0 PAUSE, 1 RUN, 2 STEP, 3 DONE.
- bp_hit  out  1  sticky: the last stop was caused by the breakpoint.
- cyc_cnt  out  CNT_W  number of cycles with cpu_en=1.

Behaviour:
Reset:
- state=PAUSE, cpu_en=0, bp_hit=0, cyc_cnt=0, en_q=0.
- Debouncer synchronisers and counters cleared.
- Reset mid-RUN stops the pipeline in the same cycle rst is sampled.

Buttons:
- Each button goes through a 2-FF synchroniser, then a stability counter.
- A pulse (1 cycle) is emitted when the synchronised level has been 1 for DEBOUNCE consecutive cycles after being accepted as 0.
- A held button produces exactly one pulse. Release must also be stable for DEBOUNCE cycles before re-arming.
- Resulting pulses: run_p, step_p, halt_p.

Internal signals:
- en_q = cpu_en registered. Marks that WB received a new instruction this cycle.
- stop_now = en_q & (halt_req | (bp_en & wb_pc==bp_addr)). Combinational.

Output decode:
- cpu_en = (state==RUN | state==STEP) & ~stop_now.
- stop_now gates cpu_en in the same cycle, so the pipeline freezes with the terminating or breakpoint instruction held in WB. No extra instruction advances.

Transitions, priority top to bottom, evaluated every cycle:
- DONE: stays until rst. All buttons are ignored.
- Any state with en_q & halt_req: go to DONE, bp_hit=0.
- RUN/STEP with stop_now by breakpoint: go to PAUSE, bp_hit=1.
- RUN with halt_p: go to PAUSE.
- STEP: always returns to PAUSE after its single cycle, so exactly one cpu_en pulse per step.
- PAUSE with run_p: go to RUN, bp_hit=0. run_p wins if run_p and step_p arrive in the same cycle.
- PAUSE with step_p: go to STEP, bp_hit=0.
- RUN ignores step_p and run_p. PAUSE ignores halt_p.

Breakpoint resume:
- After a breakpoint stop, en_q=0, so the same WB instruction does not re-trigger.
- The first enabled cycle after run/step moves it out of WB.

Counter:
- cyc_cnt += 1 on every cycle with cpu_en=1.
- Wraps modulo 2^CNT_W with no saturation.

Decomposition:
- Shared package: run_state encodings (ST_PAUSE=0, ST_RUN=1, ST_STEP=2, ST_DONE=3) and DEBOUNCE default, so display and top-level muxing can decode run_state.
- One sub-module, btn_debounce (sync, stability counter, rising-pulse out), instantiated three times.
- FSM and counter stay in pipe_run_ctrl.

Test Plan (DEBOUNCE=4):
1. Reset then idle 20 cycles -> cpu_en=0, run_state=0, cyc_cnt=0.
2. Run pulse:
   - btn_run high 10 cycles -> one run_p, run_state=1 and cpu_en=1 continuously.
   - btn_run glitch of 2 cycles -> no state change.
3. PAUSE, btn_step held 50 cycles -> exactly one cpu_en cycle, cyc_cnt +1, back to run_state=0. Second press -> cyc_cnt +1 again.
4. Breakpoint, bp_en=1, bp_addr=0x0000_0010:
   - RUN; model wb_pc advancing 4 per enabled cycle.
   - When en_q=1 and wb_pc=0x10 -> cpu_en=0 that cycle, run_state=0, bp_hit=1.
   - Run again -> no immediate re-stop; next wb_pc=0x14 retires; bp_hit=0.
5. RUN with halt_req asserted alongside en_q -> cpu_en=0 same cycle, run_state=3. Run/step presses are then ignored; rst returns to PAUSE.
6. Simultaneous events:
   - run_p and step_p together in PAUSE -> RUN.
   - halt_req and breakpoint match together -> DONE with bp_hit=0.
   - cyc_cnt preset near 2^CNT_W-1 (CNT_W=4 build) wraps to 0.

Source files
------------

// File: rtl/pipe_run_ctrl_pkg.sv
// Shared encodings for the pipeline run/step/halt controller, so display logic
// and top-level muxing can decode run_state without duplicating constants.
package pipe_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  localparam int DEBOUNCE_DEFAULT = 20000;

endpackage : pipe_run_ctrl_pkg

// File: rtl/pipe_run_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse when a press has been stable long enough to be accepted.
module btn_debounce
  import pipe_run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int            CW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // NOTE: every register here uses <= so all flops sample pre-edge values;
  // a blocking assignment would collapse the two synchroniser stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Level differed from the accepted one for DEBOUNCE cycles in a row.
        stable <= sync2;
        cnt    <= '0;
        pulse  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule : btn_debounce

// File: rtl/pipe_run_ctrl.sv
// Run/step/halt controller: produces the single pipeline advance enable and
// sequences free-run, single-step, PC breakpoint and exit-syscall stops.
module pipe_run_ctrl
  import pipe_run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_halt,
  input  logic             halt_req,
  input  logic [31:0]      wb_pc,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  output logic             cpu_en,
  output logic [1:0]       run_state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cyc_cnt
);

  logic run_p;
  logic step_p;
  logic halt_p;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_run (
    .clk(clk), .rst(rst), .btn(btn_run), .pulse(run_p)
  );
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_step (
    .clk(clk), .rst(rst), .btn(btn_step), .pulse(step_p)
  );
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_halt (
    .clk(clk), .rst(rst), .btn(btn_halt), .pulse(halt_p)
  );

  run_state_e       state_q;
  run_state_e       state_d;
  logic             bp_hit_q;
  logic             bp_hit_d;
  logic             en_q;
  logic [CNT_W-1:0] cyc_q;
  logic             stop_now;
  logic             active;

  // en_q qualifies the WB compare: only a freshly arrived instruction may stop
  // the pipe, so resuming from a breakpoint does not re-trigger on it.
  assign stop_now = en_q & (halt_req | (bp_en & (wb_pc == bp_addr)));
  assign active   = (state_q == ST_RUN) | (state_q == ST_STEP);
  assign cpu_en   = ~rst & active & ~stop_now;

  // NOTE: next-state values take their defaults first, so a path through the
  // priority chain that assigns nothing holds state instead of inferring a latch.
  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    if (state_q != ST_DONE) begin
      if (en_q & halt_req) begin
        state_d  = ST_DONE;
        bp_hit_d = 1'b0;
      end else if (active & stop_now) begin
        state_d  = ST_PAUSE;
        bp_hit_d = 1'b1;
      end else if ((state_q == ST_RUN) & halt_p) begin
        state_d = ST_PAUSE;
      end else if (state_q == ST_STEP) begin
        state_d = ST_PAUSE;
      end else if ((state_q == ST_PAUSE) & run_p) begin
        state_d  = ST_RUN;
        bp_hit_d = 1'b0;
      end else if ((state_q == ST_PAUSE) & step_p) begin
        state_d  = ST_STEP;
        bp_hit_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PAUSE;
      bp_hit_q <= 1'b0;
      en_q     <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      bp_hit_q <= bp_hit_d;
      en_q     <= cpu_en;
      if (cpu_en) begin
        cyc_q <= cyc_q + 1'b1;
      end
    end
  end

  assign run_state = state_q;
  assign bp_hit    = bp_hit_q;
  assign cyc_cnt   = cyc_q;

endmodule : pipe_run_ctrl

// File: tb/tb_pipe_run_ctrl.sv
// Self-checking bench for pipe_run_ctrl: table-driven button vectors, directed
// breakpoint/exit sequences and random stimulus against a behavioural model.
module tb_pipe_run_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_run, btn_step, btn_halt;
  logic        halt_req;
  logic [31:0] wb_pc;
  logic        bp_en;
  logic [31:0] bp_addr;

  logic        cpu_en, bp_hit;
  logic [1:0]  run_state;
  logic [31:0] cyc_cnt;
  logic        cpu_en4, bp_hit4;
  logic [1:0]  run_state4;
  logic [3:0]  cyc_cnt4;

  pipe_run_ctrl #(.DEBOUNCE(D), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .btn_halt(btn_halt), .halt_req(halt_req), .wb_pc(wb_pc), .bp_en(bp_en),
    .bp_addr(bp_addr), .cpu_en(cpu_en), .run_state(run_state),
    .bp_hit(bp_hit), .cyc_cnt(cyc_cnt)
  );

  // Narrow-counter build sharing all inputs, so wrap-around is exercised.
  pipe_run_ctrl #(.DEBOUNCE(D), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .btn_halt(btn_halt), .halt_req(halt_req), .wb_pc(wb_pc), .bp_en(bp_en),
    .bp_addr(bp_addr), .cpu_en(cpu_en4), .run_state(run_state4),
    .bp_hit(bp_hit4), .cyc_cnt(cyc_cnt4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 pause, 1 run, 2 step, 3 done.
  int          m_st;
  bit          m_bp, m_enq;
  logic [31:0] m_cyc;
  bit          m_pulse[3];
  bit          m_acc[3];
  bit          raw_q[3][$];
  bit          sync_q[3][$];

  // Bench-side pipeline: WB PC advances by 4 per enabled cycle.
  logic [31:0] pipe_pc = '0;
  logic [31:0] halt_at = '0;
  bit          halt_on = 1'b0;

  function automatic void model_reset();
    m_st  = 0;
    m_bp  = 1'b0;
    m_enq = 1'b0;
    m_cyc = '0;
    for (int b = 0; b < 3; b++) begin
      m_pulse[b] = 1'b0;
      m_acc[b]   = 1'b0;
      raw_q[b].delete();
      raw_q[b].push_back(1'b0);
      raw_q[b].push_back(1'b0);
      sync_q[b].delete();
    end
  endfunction

  // One clock: drive derived inputs, compare at negedge+1, advance model at posedge.
  task automatic step_cycle();
    bit btn[3];
    bit m_stop, m_cpu, s2, flip;
    int nst;
    bit nbp;
    wb_pc    = pipe_pc;
    halt_req = halt_on && (pipe_pc == halt_at);
    #1;
    m_stop = m_enq && (halt_req || (bp_en && (wb_pc == bp_addr)));
    m_cpu  = !rst && (m_st == 1 || m_st == 2) && !m_stop;
    check("cpu_en",     32'(cpu_en),     32'(m_cpu));
    check("run_state",  32'(run_state),  32'(m_st));
    check("bp_hit",     32'(bp_hit),     32'(m_bp));
    check("cyc_cnt",    cyc_cnt,         m_cyc);
    check("cpu_en_w4",  32'(cpu_en4),    32'(m_cpu));
    check("cyc_cnt_w4", 32'(cyc_cnt4),   32'(m_cyc[3:0]));
    @(posedge clk);
    btn[0] = btn_run;
    btn[1] = btn_step;
    btn[2] = btn_halt;
    if (rst) begin
      model_reset();
    end else begin
      nst = m_st;
      nbp = m_bp;
      if (m_st != 3) begin
        if (m_enq && halt_req) begin nst = 3; nbp = 1'b0; end
        else if ((m_st == 1 || m_st == 2) && m_stop) begin nst = 0; nbp = 1'b1; end
        else if (m_st == 1 && m_pulse[2]) nst = 0;
        else if (m_st == 2) nst = 0;
        else if (m_st == 0 && m_pulse[0]) begin nst = 1; nbp = 1'b0; end
        else if (m_st == 0 && m_pulse[1]) begin nst = 2; nbp = 1'b0; end
      end
      m_st  = nst;
      m_bp  = nbp;
      m_enq = m_cpu;
      if (m_cpu) begin
        m_cyc   = m_cyc + 1;
        pipe_pc = pipe_pc + 32'd4;
      end
      // A button is accepted once its synchronised level has differed from
      // the accepted level over the whole of the last D cycles.
      for (int b = 0; b < 3; b++) begin
        s2 = raw_q[b][0];
        raw_q[b].push_back(btn[b]);
        void'(raw_q[b].pop_front());
        sync_q[b].push_back(s2);
        if (sync_q[b].size() > D) void'(sync_q[b].pop_front());
        flip = (sync_q[b].size() == D);
        foreach (sync_q[b][i]) if (sync_q[b][i] == m_acc[b]) flip = 1'b0;
        m_pulse[b] = flip && s2;
        if (flip) m_acc[b] = s2;
      end
    end
    @(negedge clk);
  endtask

  task automatic press(input bit r, input bit s, input bit h, input int hold, input int idle);
    btn_run  = r;
    btn_step = s;
    btn_halt = h;
    repeat (hold) step_cycle();
    btn_run  = 1'b0;
    btn_step = 1'b0;
    btn_halt = 1'b0;
    repeat (idle) step_cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string name;
    bit    run, step, halt;
    int    hold, idle;
    int    exp_state;
    int    exp_delta;
    bit    exp_bp;
  } vec_t;

  function automatic vec_t mk(input string n, input bit r, input bit s, input bit h,
                              input int hold, input int idle, input int st,
                              input int dl, input bit bp);
    vec_t v;
    v.name = n; v.run = r; v.step = s; v.halt = h; v.hold = hold; v.idle = idle;
    v.exp_state = st; v.exp_delta = dl; v.exp_bp = bp;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    int          n;
    int          hold_left[3];

    // Button press latency: 2 sync + 4 stable cycles, then one FSM cycle.
    tbl[0]  = mk("run_press",       1, 0, 0, 10, 10, 1, 13, 0);
    tbl[1]  = mk("run_glitch_run",  1, 0, 0,  2, 10, 1, 12, 0);
    tbl[2]  = mk("step_in_run",     0, 1, 0, 10, 10, 1, 20, 0);
    tbl[3]  = mk("halt_from_run",   0, 0, 1, 10, 10, 0,  7, 0);
    tbl[4]  = mk("step_held_50",    0, 1, 0, 50, 10, 0,  1, 0);
    tbl[5]  = mk("step_again",      0, 1, 0, 10, 10, 0,  1, 0);
    tbl[6]  = mk("step_glitch",     0, 1, 0,  2, 10, 0,  0, 0);
    tbl[7]  = mk("halt_in_pause",   0, 0, 1, 10, 10, 0,  0, 0);
    tbl[8]  = mk("run_glitch",      1, 0, 0,  2, 10, 0,  0, 0);
    tbl[9]  = mk("run_and_step",    1, 1, 0, 10, 10, 1, 13, 0);
    tbl[10] = mk("halt_again",      0, 0, 1, 10, 10, 0,  7, 0);

    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; btn_halt = 1'b0;
    halt_req = 1'b0; wb_pc = '0; bp_en = 1'b0; bp_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Idle after reset.
    repeat (20) step_cycle();
    check("reset_state", 32'(run_state), 32'd0);
    check("reset_cnt",   cyc_cnt,        32'd0);
    check("reset_en",    32'(cpu_en),    32'd0);

    foreach (tbl[i]) begin
      base = m_cyc;
      press(tbl[i].run, tbl[i].step, tbl[i].halt, tbl[i].hold, tbl[i].idle);
      check({tbl[i].name, "_state"}, 32'(run_state), 32'(tbl[i].exp_state));
      check({tbl[i].name, "_cnt"},   cyc_cnt,        base + 32'(tbl[i].exp_delta));
      check({tbl[i].name, "_bp"},    32'(bp_hit),    32'(tbl[i].exp_bp));
    end

    // Reset while running drops cpu_en in the cycle rst is sampled.
    press(1, 0, 0, 10, 10);
    rst = 1'b1;
    wb_pc = pipe_pc;
    #1;
    check("rst_midrun_en", 32'(cpu_en), 32'd0);
    step_cycle();
    rst = 1'b0;
    check("rst_midrun_state", 32'(run_state), 32'd0);

    // Breakpoint at 0x10: stops with it held in WB, resume moves past it.
    pipe_pc = 32'h0; bp_en = 1'b1; bp_addr = 32'h10;
    press(1, 0, 0, 10, 10);
    check("bp_stop_state", 32'(run_state), 32'd0);
    check("bp_stop_hit",   32'(bp_hit),    32'd1);
    check("bp_stop_pc",    wb_pc,          32'h10);
    check("bp_stop_cnt",   cyc_cnt,        32'd4);
    press(1, 0, 0, 7, 0);
    check("bp_resume_pc",  wb_pc,          32'h10);
    step_cycle();
    check("bp_resume_next", pipe_pc,       32'h14);
    check("bp_resume_hit", 32'(bp_hit),    32'd0);
    press(0, 0, 1, 10, 10);
    check("bp_resume_state", 32'(run_state), 32'd0);

    // Exit syscall: DONE, buttons ignored until reset.
    bp_en = 1'b0; halt_on = 1'b1; halt_at = pipe_pc + 32'h20;
    press(1, 0, 0, 10, 10);
    check("done_state", 32'(run_state), 32'd3);
    check("done_pc",    wb_pc,          halt_at);
    base = m_cyc;
    press(1, 0, 0, 10, 10);
    press(0, 1, 0, 10, 10);
    check("done_ignore_state", 32'(run_state), 32'd3);
    check("done_ignore_cnt",   cyc_cnt,        base);
    rst = 1'b1; step_cycle(); rst = 1'b0;
    check("done_rst_state", 32'(run_state), 32'd0);

    // Halt and breakpoint on the same WB instruction: DONE, bp_hit cleared.
    halt_on = 1'b0; pipe_pc = 32'h0; bp_en = 1'b1; bp_addr = 32'h10;
    press(1, 0, 0, 10, 10);
    check("pre_both_hit", 32'(bp_hit), 32'd1);
    bp_addr = 32'h20; halt_at = 32'h20; halt_on = 1'b1;
    n = 0;
    btn_run = 1'b1;
    while (run_state !== 2'd3 && n < 60) begin
      step_cycle();
      n++;
    end
    btn_run = 1'b0;
    check("both_state", 32'(run_state), 32'd3);
    check("both_hit",   32'(bp_hit),    32'd0);
    check("both_pc",    wb_pc,          32'h20);
    rst = 1'b1; step_cycle(); rst = 1'b0;

    // Random stimulus against the model.
    pipe_pc = 32'h0; halt_on = 1'b0; bp_en = 1'b0;
    hold_left = '{0, 0, 0};
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold_left[b] == 0) begin
          hold_left[b] = int'($urandom_range(1, 15));
          case (b)
            0: btn_run  = ($urandom_range(0, 2) == 0);
            1: btn_step = ($urandom_range(0, 2) == 0);
            default: btn_halt = ($urandom_range(0, 3) == 0);
          endcase
        end else begin
          hold_left[b]--;
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      if (rst) begin
        pipe_pc = 32'h0;
        bp_en   = $urandom_range(0, 1) == 1;
        bp_addr = 32'($urandom_range(1, 64)) << 2;
        halt_on = $urandom_range(0, 1) == 1;
        halt_at = 32'($urandom_range(1, 128)) << 2;
      end
      step_cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_run_ctrl
